defuzz9: RTL

DEFUZZ9 -- requirements
Module: defuzz9

---
 rtl/fuzzy_pkg.sv | 16 +
 rtl/div_restoring.sv | 57 +++++
 rtl/defuzz9.sv | 109 ++++++++++
 3 files changed

// File: rtl/fuzzy_pkg.sv
// fuzzy_pkg: widths, FSM states, default singleton table and output saturation
package fuzzy_pkg;
    localparam int W_W   = 16;
    localparam int Y_W   = 16;
    localparam int NUM_W = 36;
    localparam int DEN_W = 20;
    typedef enum logic [1:0] {IDLE, ACC, DIV, DONE} state_t;
    typedef logic [0:2][0:2][15:0] ctab_t;
    localparam ctab_t C_DEFAULT = '{'{16'hC000, 16'hE000, 16'h0000},
                                    '{16'hE000, 16'h0000, 16'h2000},
                                    '{16'h0000, 16'h2000, 16'h4000}};
    function automatic logic [Y_W-1:0] sat_y(input logic [NUM_W-1:0] mag, input logic neg);
        return neg ? (mag > 36'd32768 ? 16'h8000 : 16'(-mag))
                   : (mag > 36'd32767 ? 16'h7FFF : mag[15:0]);
    endfunction
endpackage

// File: rtl/div_restoring.sv
// div_restoring: unsigned restoring divider, result presented with done on the 36th edge after start
module div_restoring
    import fuzzy_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NUM_W-1:0] n,
    input  logic [DEN_W-1:0] d,
    output logic             done,
    output logic [NUM_W-1:0] q
);
    logic             busy_q, busy_d;
    logic [5:0]       cnt_q, cnt_d;
    logic [NUM_W-1:0] quo_q, quo_d;
    logic [DEN_W-1:0] rem_q, rem_d, dv_q, dv_d;
    logic [DEN_W:0]   sh;
    logic             ge;
    always_comb begin
        sh     = {rem_q, quo_q[NUM_W-1]};
        ge     = sh >= {1'b0, dv_q};
        q      = {quo_q[NUM_W-2:0], ge};
        done   = busy_q && cnt_q == 6'(NUM_W - 1);
        busy_d = busy_q;
        cnt_d  = cnt_q;
        quo_d  = quo_q;
        rem_d  = rem_q;
        dv_d   = dv_q;
        if (start) begin
            busy_d = 1'b1;
            cnt_d  = '0;
            quo_d  = n;
            rem_d  = '0;
            dv_d   = d;
        end else if (busy_q) begin
            quo_d  = q;
            rem_d  = ge ? DEN_W'(sh - {1'b0, dv_q}) : sh[DEN_W-1:0];
            cnt_d  = cnt_q + 6'd1;
            busy_d = !done;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            dv_q   <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            dv_q   <= dv_d;
        end
    end
endmodule

// File: rtl/defuzz9.sv
// defuzz9: nine-rule weighted-average defuzzifier with serial MAC and serial divide
module defuzz9
    import fuzzy_pkg::*;
#(
    parameter ctab_t C_TABLE = C_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W_W-1:0]   w00, w01, w02, w10, w11, w12, w20, w21, w22,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [Y_W-1:0]   y,
    output logic             y_zero
);
    localparam logic [0:8][15:0] C_FLAT = C_TABLE;
    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d, idx;
    logic [0:8][W_W-1:0]     w_q, w_d;
    logic signed [32:0]      prod_q, prod_d;
    logic signed [NUM_W-1:0] num_q, num_d;
    logic [DEN_W-1:0]        den_q, den_d;
    logic [Y_W-1:0]          y_q, y_d;
    logic                    yz_q, yz_d;
    logic [W_W-1:0]          w_cur;
    logic signed [16:0]      w_s;
    logic signed [15:0]      c_s;
    logic [NUM_W-1:0]        num_abs, div_q;
    logic                    div_start, div_done;
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        w_d       = w_q;
        num_d     = num_q;
        den_d     = den_q;
        y_d       = y_q;
        yz_d      = yz_q;
        div_start = 1'b0;
        idx       = cnt_q < 4'd9 ? cnt_q : 4'd0;
        w_cur     = w_q[idx];
        w_s       = $signed({1'b0, w_cur});
        c_s       = $signed(C_FLAT[idx]);
        prod_d    = w_s * c_s;
        // the product is registered, so ACC spends one extra cycle draining it into num
        case (state_q)
            IDLE: if (in_valid) begin
                w_d     = {w00, w01, w02, w10, w11, w12, w20, w21, w22};
                cnt_d   = '0;
                num_d   = '0;
                den_d   = '0;
                state_d = ACC;
            end
            ACC: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q < 4'd9) den_d = den_q + {4'b0, w_cur};
                if (cnt_q != 4'd0) num_d = num_q + $signed({{3{prod_q[32]}}, prod_q});
                if (cnt_q == 4'd9) begin
                    cnt_d     = '0;
                    state_d   = den_q == '0 ? DONE : DIV;
                    div_start = den_q != '0;
                    y_d       = '0;
                    yz_d      = den_q == '0;
                end
            end
            DIV: if (div_done) begin
                y_d     = sat_y(div_q, num_q[NUM_W-1]);
                yz_d    = 1'b0;
                state_d = DONE;
            end
            default: if (out_ready) state_d = IDLE;
        endcase
        num_abs = num_d[NUM_W-1] ? -num_d : num_d;
    end
    div_restoring u_div (
        .clk   (clk),
        .rst   (rst),
        .start (div_start),
        .n     (num_abs),
        .d     (den_q),
        .done  (div_done),
        .q     (div_q)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            w_q     <= '0;
            prod_q  <= '0;
            num_q   <= '0;
            den_q   <= '0;
            y_q     <= '0;
            yz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            w_q     <= w_d;
            prod_q  <= prod_d;
            num_q   <= num_d;
            den_q   <= den_d;
            y_q     <= y_d;
            yz_q    <= yz_d;
        end
    end
    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign y         = y_q;
    assign y_zero    = yz_q;
endmodule
